// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the 16-entry gray-pointer FIFO.
//   ADDR_W : pointer / address width (4, matches the 4-bit gray decoders)
//   DEPTH  : physical storage entries (16)
//   USABLE : usable entries (15); one slot is always kept empty so that
//            full and empty can be told apart without an extra wrap bit
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int USABLE = DEPTH - 1;

  typedef logic [ADDR_W-1:0] ptr_t;

  // Pointer increment with natural modulo-DEPTH wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_ctrl_if
// Bundles the write-side handshake, storage write port and pointer-crossing
// signals of the FIFO write pointer controller.
//   push_valid    : producer requests a write
//   push_ready    : controller can accept a write
//   mem_we        : storage write enable
//   mem_waddr     : storage binary write address
//   wr_gray       : registered gray write pointer for the read side
//   rd_gray_async : gray read pointer from the read domain (unsynchronised)
//   full          : 15 entries occupied
//   almost_full   : free_cnt at or below threshold
//   free_cnt      : free slots, 0..15
// Modports: master = producer / read-side environment, slave = controller.
// ---------------------------------------------------------------------------
interface fifo_wr_ptr_ctrl_if;
  import fifo_pkg::*;

  logic push_valid;
  logic push_ready;
  logic mem_we;
  ptr_t mem_waddr;
  ptr_t wr_gray;
  ptr_t rd_gray_async;
  logic full;
  logic almost_full;
  ptr_t free_cnt;

  modport master (
    output push_valid,
    output rd_gray_async,
    input  push_ready,
    input  mem_we,
    input  mem_waddr,
    input  wr_gray,
    input  full,
    input  almost_full,
    input  free_cnt
  );

  modport slave (
    input  push_valid,
    input  rd_gray_async,
    output push_ready,
    output mem_we,
    output mem_waddr,
    output wr_gray,
    output full,
    output almost_full,
    output free_cnt
  );

endinterface

// File: rtl/b2g_decoder.sv
// ---------------------------------------------------------------------------
// b2g_decoder
// Combinational 4-bit binary to gray conversion.
//   bin  : binary input
//   gray : gray-coded output
// ---------------------------------------------------------------------------
module b2g_decoder
  import fifo_pkg::*;
(
  input  ptr_t bin,
  output ptr_t gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/g2b_decoder.sv
// ---------------------------------------------------------------------------
// g2b_decoder
// Combinational 4-bit gray to binary conversion. Every one of the 16 codes
// decodes to a defined value, so a glitched input is harmless here.
//   gray : gray-coded input
//   bin  : binary output
// ---------------------------------------------------------------------------
module g2b_decoder
  import fifo_pkg::*;
(
  input  ptr_t gray,
  output ptr_t bin
);

  // Each binary bit is the XOR of all gray bits at and above it.
  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bit
    assign bin[gi] = ^gray[ADDR_W-1:gi];
  end

endmodule

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser of parameterised width with synchronous active-high
// reset to zero. Intended for gray-coded buses where at most one bit moves
// per source clock.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronised output (two edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
// Write-side pointer controller for the 16-entry gray-pointer FIFO.
// Accepts pushes, drives the storage write port, keeps the binary write
// pointer and its registered gray copy, synchronises the read-side gray
// pointer and derives full / almost_full / free_cnt.
//   clk  : write-domain clock
//   rst  : synchronous active-high reset
//   bus  : fifo_wr_ptr_ctrl_if.slave (handshake, storage port, pointers,
//          status)
// Parameter AF_THRESH: almost_full when free_cnt <= AF_THRESH (0..14).
// ---------------------------------------------------------------------------
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_ptr_ctrl_if.slave   bus
);

  localparam ptr_t AF_T = ptr_t'(AF_THRESH);

  ptr_t wr_bin_reg;
  ptr_t wr_gray_reg;
  ptr_t wr_bin_inc;
  ptr_t wr_gray_inc;
  ptr_t rd_sync2;
  ptr_t rd_bin;
  ptr_t free_cnt;
  logic full;
  logic push;

  // Read pointer crossing: two flops, then decode to binary.
  sync_2ff #(
    .WIDTH (ADDR_W)
  ) u_rd_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rd_gray_async),
    .q   (rd_sync2)
  );

  g2b_decoder u_rd_g2b (
    .gray (rd_sync2),
    .bin  (rd_bin)
  );

  // Gray code of the next write pointer, registered on accept so the read
  // side only ever sees a glitch-free single-bit change.
  assign wr_bin_inc = ptr_inc(wr_bin_reg);

  b2g_decoder u_wr_b2g (
    .bin  (wr_bin_inc),
    .gray (wr_gray_inc)
  );

  // Status is derived from registers only; the synchronised read pointer
  // lags, so full can only be pessimistic.
  assign full     = (wr_bin_inc == rd_bin);
  assign free_cnt = rd_bin - wr_bin_reg - ptr_t'(1);
  assign push     = bus.push_valid & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_reg  <= '0;
      wr_gray_reg <= '0;
    end else if (push) begin
      wr_bin_reg  <= wr_bin_inc;
      wr_gray_reg <= wr_gray_inc;
    end
  end

  assign bus.push_ready  = ~full;
  assign bus.mem_we      = push;
  assign bus.mem_waddr   = wr_bin_reg;
  assign bus.wr_gray     = wr_gray_reg;
  assign bus.full        = full;
  assign bus.free_cnt    = free_cnt;
  assign bus.almost_full = (free_cnt <= AF_T);

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ptr_ctrl
// Directed bench for fifo_wr_ptr_ctrl: fill, hold while full, release,
// wrap, gray stepping with a trailing read pointer, mid-operation reset and
// a push coinciding with read-pointer movement.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ptr_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_wr_ptr_ctrl_if bus ();

  fifo_wr_ptr_ctrl #(
    .AF_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s got %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.push_valid    = 1'b0;
    bus.rd_gray_async = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  logic [3:0] model_wr;
  logic [3:0] prev_gray;
  logic       pv;
  logic       last_pushed;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_full",        bus.full,        0);
    check("rst_ready",       bus.push_ready,  1);
    check("rst_afull",       bus.almost_full, 0);
    check("rst_free",        bus.free_cnt,    15);
    check("rst_waddr",       bus.mem_waddr,   0);
    check("rst_wgray",       bus.wr_gray,     0);
    check("rst_we_idle",     bus.mem_we,      0);

    // ---------------- fill with 15 pushes ----------------
    bus.push_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("fill_waddr_%0d", i), bus.mem_waddr,   i);
      check($sformatf("fill_we_%0d", i),    bus.mem_we,      1);
      check($sformatf("fill_free_%0d", i),  bus.free_cnt,    15 - i);
      check($sformatf("fill_af_%0d", i),    bus.almost_full, (15 - i) <= 2);
      tick();
    end
    #1;
    check("full_after15",  bus.full,        1);
    check("ready_after15", bus.push_ready,  0);
    check("free_after15",  bus.free_cnt,    0);
    check("af_after15",    bus.almost_full, 1);

    // ---------------- push held while full ----------------
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_we_%0d", i),    bus.mem_we,    0);
      check($sformatf("hold_waddr_%0d", i), bus.mem_waddr, 15);
      check($sformatf("hold_gray_%0d", i),  bus.wr_gray,   4'b1000);
      tick();
      #1;
    end

    // ---------------- release one slot ----------------
    bus.push_valid    = 1'b0;
    bus.rd_gray_async = 4'b0001;
    #1;
    check("rel_full_c0", bus.full, 1);
    tick(); #1;
    check("rel_full_c1", bus.full, 1);
    tick(); #1;
    check("rel_full_c2", bus.full,     0);
    check("rel_free_c2", bus.free_cnt, 1);

    // one push wraps wr_bin 15 -> 0
    bus.push_valid = 1'b1;
    #1;
    check("wrap_we", bus.mem_we, 1);
    tick();
    bus.push_valid = 1'b0;
    #1;
    check("wrap_full",  bus.full,      1);
    check("wrap_waddr", bus.mem_waddr, 0);
    check("wrap_gray",  bus.wr_gray,   4'b0000);

    // ---------------- gray stepping, read side 3 behind ----------------
    do_reset();
    model_wr    = 4'd0;
    prev_gray   = 4'd0;
    last_pushed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pv = 1'($urandom_range(0, 1));
      bus.push_valid    = pv;
      bus.rd_gray_async = bin2gray(model_wr - 4'd3);
      #1;
      check($sformatf("gray_waddr_%0d", i), bus.mem_waddr, model_wr);
      check($sformatf("gray_code_%0d", i),  bus.wr_gray,   bin2gray(model_wr));
      check($sformatf("gray_we_%0d", i),    bus.mem_we,    pv);
      check($sformatf("gray_step_%0d", i),  $countones(bus.wr_gray ^ prev_gray),
            last_pushed ? 1 : 0);
      prev_gray   = bus.wr_gray;
      last_pushed = pv;
      tick();
      if (pv) model_wr = model_wr + 4'd1;
    end

    // ---------------- reset mid-operation ----------------
    do_reset();
    bus.push_valid = 1'b1;
    repeat (9) tick();
    #1;
    check("mid_waddr9", bus.mem_waddr, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.push_valid = 1'b0;
    #1;
    check("mid_waddr", bus.mem_waddr, 0);
    check("mid_gray",  bus.wr_gray,   0);
    check("mid_free",  bus.free_cnt,  15);
    check("mid_full",  bus.full,      0);

    // ---------------- push while read pointer moves ----------------
    bus.push_valid = 1'b1;
    repeat (14) tick();
    #1;
    check("sim_free1", bus.free_cnt, 1);
    check("sim_we",    bus.mem_we,   1);
    check("sim_full0", bus.full,     0);
    tick();
    // read pointer moves at the same edge that accepted the last push
    bus.push_valid    = 1'b0;
    bus.rd_gray_async = 4'b0001;
    #1;
    check("sim_full_c1", bus.full,     1);
    check("sim_free_c1", bus.free_cnt, 0);
    tick(); #1;
    check("sim_full_c2", bus.full, 1);
    tick(); #1;
    check("sim_full_c3", bus.full,     0);
    check("sim_free_c3", bus.free_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
